checkout_sequencer: RTL and testbench

Sequences end-of-sale checkout for the terminal. On a checkout command it freezes the basket total, collects a decimal payment amount digit by digit, and compares it with the total. It then presents the change and issues the one-cycle active-low reset pulse that clears BasketController. It sits between StateMachine (commands and payment digits) and BasketController (T_PRICE, BasketProductNum, reset). It exports status for the VGA and LED controllers.

---
 rtl/checkout_sequencer.sv | 160 ++++++++++++++++
 tb/tb_checkout_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/checkout_sequencer.sv
// checkout_sequencer: end-of-sale sequencing between StateMachine and BasketController.
// Freezes the basket total, collects a decimal payment, compares it, shows the change
// and issues the one-cycle active-low basket clear.
// Optional feature: define COLLECT_TIMEOUT_EN to abandon payment entry after
// TIMEOUT_CYCLES idle cycles in COLLECT (Timeout_Pulse is tied low otherwise).
module checkout_sequencer #(
    parameter int unsigned MAX_PAY_DIGITS = 6,
    parameter int unsigned DISPLAY_CYCLES = 100000000,
    parameter int unsigned TIMEOUT_CYCLES = 1500000000
) (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic        Checkout_Pulse,
    input  logic        Cancel_Pulse,
    input  logic        Pay_Digit_En,
    input  logic [3:0]  Pay_Digit,
    input  logic        Pay_Confirm_Pulse,
    input  logic [19:0] T_PRICE,
    input  logic [3:0]  BasketProductNum,
    output logic        BasketController_RSTN_Pulse,
    output logic        Busy,
    output logic [2:0]  State_out,
    output logic [19:0] PaidAmount,
    output logic [19:0] Change,
    output logic        Insufficient,
    output logic        Done_Pulse,
    output logic        Timeout_Pulse
);

    // One counter width covers both the PAID display hold and the COLLECT inactivity limit
    localparam int unsigned CNT_MAX = (DISPLAY_CYCLES > TIMEOUT_CYCLES) ? DISPLAY_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned DIG_W   = $clog2(MAX_PAY_DIGITS + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        COMPARE = 3'd2,
        PAID    = 3'd3,
        CLEAR   = 3'd4
    } state_t;

    state_t             state;
    logic [19:0]        total_q;
    logic [DIG_W-1:0]   count;
    logic [CNT_W-1:0]   disp_cnt;
    logic               digit_ok;
`ifdef COLLECT_TIMEOUT_EN
    logic [CNT_W-1:0]   idle_cnt;
`endif

    assign State_out = state;

    // A digit is taken only if it is decimal and there is room for it
    assign digit_ok = Pay_Digit_En && (Pay_Digit <= 4'd9) && (count < DIG_W'(MAX_PAY_DIGITS));

`ifndef COLLECT_TIMEOUT_EN
    assign Timeout_Pulse = 1'b0;
`endif

    // Checkout FSM with registered outputs and strobes
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state                       <= IDLE;
            total_q                     <= '0;
            count                       <= '0;
            disp_cnt                    <= '0;
            PaidAmount                  <= '0;
            Change                      <= '0;
            Insufficient                <= 1'b0;
            Done_Pulse                  <= 1'b0;
            Busy                        <= 1'b0;
            BasketController_RSTN_Pulse <= 1'b1;
`ifdef COLLECT_TIMEOUT_EN
            idle_cnt                    <= '0;
            Timeout_Pulse               <= 1'b0;
`endif
        end else begin
            BasketController_RSTN_Pulse <= 1'b1;
            Done_Pulse                  <= 1'b0;
`ifdef COLLECT_TIMEOUT_EN
            Timeout_Pulse               <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (Checkout_Pulse && (BasketProductNum != 4'd0)) begin
                        state        <= COLLECT;
                        Busy         <= 1'b1;
                        total_q      <= T_PRICE;
                        PaidAmount   <= '0;
                        count        <= '0;
                        Insufficient <= 1'b0;
                        Change       <= '0;
`ifdef COLLECT_TIMEOUT_EN
                        idle_cnt     <= '0;
`endif
                    end
                end
                COLLECT: begin
                    if (Cancel_Pulse) begin
                        state      <= IDLE;
                        Busy       <= 1'b0;
                        PaidAmount <= '0;
                        count      <= '0;
                    end else if (Pay_Confirm_Pulse) begin
                        state <= COMPARE;
                    end else if (digit_ok) begin
                        PaidAmount   <= 20'(24'(PaidAmount) * 24'd10 + 24'(Pay_Digit));
                        count        <= count + DIG_W'(1);
                        Insufficient <= 1'b0;
`ifdef COLLECT_TIMEOUT_EN
                        idle_cnt     <= '0;
                    end else if (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state         <= IDLE;
                        Busy          <= 1'b0;
                        PaidAmount    <= '0;
                        count         <= '0;
                        Timeout_Pulse <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + CNT_W'(1);
`endif
                    end
                end
                COMPARE: begin
                    if (PaidAmount >= total_q) begin
                        Change   <= PaidAmount - total_q;
                        disp_cnt <= CNT_W'(DISPLAY_CYCLES - 1);
                        state    <= PAID;
                    end else begin
                        Insufficient <= 1'b1;
                        PaidAmount   <= '0;
                        count        <= '0;
                        state        <= COLLECT;
`ifdef COLLECT_TIMEOUT_EN
                        idle_cnt     <= '0;
`endif
                    end
                end
                PAID: begin
                    if (disp_cnt == '0) begin
                        state                       <= CLEAR;
                        BasketController_RSTN_Pulse <= 1'b0;
                        Done_Pulse                  <= 1'b1;
                    end else begin
                        disp_cnt <= disp_cnt - CNT_W'(1);
                    end
                end
                CLEAR: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_checkout_sequencer.sv
// Scoreboard bench for checkout_sequencer (default build, DISPLAY_CYCLES=4).
module tb_checkout_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        checkout = 1'b0;
    logic        cancel = 1'b0;
    logic        dig_en = 1'b0;
    logic [3:0]  dig = 4'd0;
    logic        confirm = 1'b0;
    logic [19:0] price = 20'd0;
    logic [3:0]  num = 4'd0;
    logic        rstn_pulse;
    logic        busy;
    logic [2:0]  state;
    logic [19:0] paid;
    logic [19:0] change;
    logic        insuf;
    logic        done;
    logic        tmo;

    int n_tests = 0;
    int n_fail  = 0;
    int rstn_cnt = 0;
    logic [2:0] prev_state = 3'd0;

    typedef struct {
        bit          ok;
        logic [19:0] change;
    } exp_t;
    exp_t exp_q[$];

    checkout_sequencer #(.DISPLAY_CYCLES(4)) dut (
        .CLOCK_50                    (clk),
        .RESET_N                     (rst_n),
        .Checkout_Pulse              (checkout),
        .Cancel_Pulse                (cancel),
        .Pay_Digit_En                (dig_en),
        .Pay_Digit                   (dig),
        .Pay_Confirm_Pulse           (confirm),
        .T_PRICE                     (price),
        .BasketProductNum            (num),
        .BasketController_RSTN_Pulse (rstn_pulse),
        .Busy                        (busy),
        .State_out                   (state),
        .PaidAmount                  (paid),
        .Change                      (change),
        .Insufficient                (insuf),
        .Done_Pulse                  (done),
        .Timeout_Pulse               (tmo)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pop a scoreboard entry on the cycle after each COMPARE and track clear pulses
    always @(negedge clk) begin
        if (rst_n && prev_state == 3'd2) begin
            if (exp_q.size() == 0) begin
                check_eq("cmp_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.ok) begin
                    check_eq("cmp_state_paid", 32'(state), 32'd3);
                    check_eq("cmp_change", 32'(change), 32'(e.change));
                    check_eq("cmp_insuf_lo", 32'(insuf), 32'd0);
                end else begin
                    check_eq("cmp_state_back", 32'(state), 32'd1);
                    check_eq("cmp_insuf_hi", 32'(insuf), 32'd1);
                    check_eq("cmp_paid_zero", 32'(paid), 32'd0);
                end
            end
        end
        if (!rstn_pulse) begin
            check_eq("clr_done_pair", 32'(done), 32'd1);
            rstn_cnt <= rstn_cnt + 1;
        end
        prev_state <= state;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_checkout(input logic [19:0] p, input logic [3:0] n);
        price    = p;
        num      = n;
        checkout = 1'b1;
        step();
        checkout = 1'b0;
    endtask

    task automatic do_digit(input logic [3:0] d);
        dig_en = 1'b1;
        dig    = d;
        step();
        dig_en = 1'b0;
    endtask

    task automatic do_confirm(input bit ok, input logic [19:0] chg);
        exp_t e;
        e.ok     = ok;
        e.change = chg;
        exp_q.push_back(e);
        confirm = 1'b1;
        step();
        confirm = 1'b0;
        check_eq("compare_state", 32'(state), 32'd2);
    endtask

    // Called in the COMPARE cycle of a passing payment; walks PAID and CLEAR
    task automatic finish_sale(input logic [19:0] exp_change, input logic [19:0] exp_paid);
        int paid_cycles = 0;
        step();
        while (state == 3'd3 && paid_cycles < 20) begin
            paid_cycles++;
            step();
        end
        check_eq("paid_cycles", 32'(paid_cycles), 32'd4);
        check_eq("clear_state", 32'(state), 32'd4);
        check_eq("clear_rstn", 32'(rstn_pulse), 32'd0);
        check_eq("clear_done", 32'(done), 32'd1);
        check_eq("clear_busy", 32'(busy), 32'd1);
        step();
        check_eq("post_state", 32'(state), 32'd0);
        check_eq("post_busy", 32'(busy), 32'd0);
        check_eq("post_rstn", 32'(rstn_pulse), 32'd1);
        check_eq("post_done", 32'(done), 32'd0);
        check_eq("post_change", 32'(change), 32'(exp_change));
        check_eq("post_paid", 32'(paid), 32'(exp_paid));
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_state"}, 32'(state), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_rstn"}, 32'(rstn_pulse), 32'd1);
        check_eq({tag, "_paid"}, 32'(paid), 32'd0);
        check_eq({tag, "_change"}, 32'(change), 32'd0);
        check_eq({tag, "_insuf"}, 32'(insuf), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
        check_eq({tag, "_tmo"}, 32'(tmo), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        rst_n = 1'b0;
        step();
        check_reset_values("rst");
        rst_n = 1'b1;
        step();

        // Exact payment
        do_checkout(20'd1250, 4'd3);
        check_eq("s1_collect", 32'(state), 32'd1);
        check_eq("s1_busy", 32'(busy), 32'd1);
        do_digit(4'd1); do_digit(4'd2); do_digit(4'd5); do_digit(4'd0);
        check_eq("s1_paid", 32'(paid), 32'd1250);
        do_confirm(1'b1, 20'd0);
        finish_sale(20'd0, 20'd1250);
        check_eq("s1_rstn_cnt", 32'(rstn_cnt), 32'd1);

        // Overpay with T_PRICE changing after latch
        do_checkout(20'd999, 4'd1);
        price = 20'd5;
        do_digit(4'd2); do_digit(4'd0); do_digit(4'd0); do_digit(4'd0);
        do_confirm(1'b1, 20'd1001);
        finish_sale(20'd1001, 20'd2000);

        // Underpay, then recovery by a new digit
        do_checkout(20'd500, 4'd2);
        do_digit(4'd4); do_digit(4'd9); do_digit(4'd9);
        do_confirm(1'b0, 20'd0);
        step();
        check_eq("s3_state", 32'(state), 32'd1);
        check_eq("s3_insuf", 32'(insuf), 32'd1);
        check_eq("s3_paid0", 32'(paid), 32'd0);
        do_digit(4'd6);
        check_eq("s3_insuf_clr", 32'(insuf), 32'd0);
        check_eq("s3_paid6", 32'(paid), 32'd6);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        check_eq("s3_cancel_state", 32'(state), 32'd0);

        // Digit limit and invalid digit
        do_checkout(20'd1, 4'd1);
        for (int d = 1; d <= 7; d++) do_digit(4'(d));
        do_digit(4'd12);
        check_eq("s4_paid", 32'(paid), 32'd123456);
        do_confirm(1'b1, 20'd123455);
        finish_sale(20'd123455, 20'd123456);

        // Empty basket checkout ignored
        do_checkout(20'd10, 4'd0);
        check_eq("s5_empty_state", 32'(state), 32'd0);
        check_eq("s5_empty_busy", 32'(busy), 32'd0);
        check_eq("s5_change_held", 32'(change), 32'd123455);

        // Cancel beats confirm
        do_checkout(20'd10, 4'd2);
        do_digit(4'd5);
        cancel  = 1'b1;
        confirm = 1'b1;
        step();
        cancel  = 1'b0;
        confirm = 1'b0;
        check_eq("s5_cancel_state", 32'(state), 32'd0);
        check_eq("s5_cancel_paid", 32'(paid), 32'd0);
        check_eq("s5_cancel_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 6; i++) step();
        check_eq("s5_rstn_cnt", 32'(rstn_cnt), 32'd3);

        // Empty confirm fails against nonzero total, passes against zero total
        do_checkout(20'd7, 4'd1);
        do_confirm(1'b0, 20'd0);
        step();
        check_eq("s5_empty_cmp_insuf", 32'(insuf), 32'd1);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        do_checkout(20'd0, 4'd1);
        do_confirm(1'b1, 20'd0);
        finish_sale(20'd0, 20'd0);

        // Reset in the middle of PAID
        do_checkout(20'd100, 4'd1);
        do_digit(4'd1); do_digit(4'd0); do_digit(4'd0);
        do_confirm(1'b1, 20'd0);
        step();
        step();
        check_eq("s6_in_paid", 32'(state), 32'd3);
        rst_n = 1'b0;
        step();
        check_reset_values("s6_rst");
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check_eq("s6_idle", 32'(state), 32'd0);
        check_eq("s6_rstn_cnt", 32'(rstn_cnt), 32'd4);
        check_eq("s6_tmo", 32'(tmo), 32'd0);

        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
